// File: rtl/pcie_cfg_pkg.sv
// rtl/pcie_cfg_pkg.sv - PCIe DMA configuration constants and DMA scratch SRAM FSM state type
package pcie_cfg_pkg;

   localparam int CFG_PCIE_DMAADDR_WIDTH   = 32;
   localparam int CFG_PCIE_DMA_BEATS_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      RD_ISSUE,
      RD_RESP,
      WR_RESP
   } pcie_dma_sram_state_type;

endpackage

// File: rtl/pcie_dma_sram_if.sv
// rtl/pcie_dma_sram_if.sv - DMA memory request/response channel between PCIe endpoint and scratch SRAM
interface pcie_dma_sram_if
   import pcie_cfg_pkg::*;
();

   logic                              req_mem_ready;
   logic                              req_mem_valid;
   logic                              req_mem_write;
   logic [9:0]                        req_mem_bytes;
   logic [CFG_PCIE_DMAADDR_WIDTH-1:0] req_mem_addr;
   logic [7:0]                        req_mem_strob;
   logic [63:0]                       req_mem_data;
   logic                              req_mem_last;

   logic                              resp_mem_valid;
   logic                              resp_mem_last;
   logic                              resp_mem_fault;
   logic [CFG_PCIE_DMAADDR_WIDTH-1:0] resp_mem_addr;
   logic [63:0]                       resp_mem_data;
   logic                              resp_mem_ready;

   modport master (
      input  req_mem_ready,
      output req_mem_valid, req_mem_write, req_mem_bytes, req_mem_addr,
      output req_mem_strob, req_mem_data, req_mem_last,
      input  resp_mem_valid, resp_mem_last, resp_mem_fault, resp_mem_addr, resp_mem_data,
      output resp_mem_ready
   );

   modport slave (
      output req_mem_ready,
      input  req_mem_valid, req_mem_write, req_mem_bytes, req_mem_addr,
      input  req_mem_strob, req_mem_data, req_mem_last,
      output resp_mem_valid, resp_mem_last, resp_mem_fault, resp_mem_addr, resp_mem_data,
      input  resp_mem_ready
   );

endinterface

// File: rtl/pcie_dma_sram_bank.sv
// rtl/pcie_dma_sram_bank.sv - single-port synchronous 64-bit RAM with byte enables, no reset
module pcie_dma_sram_bank #(
   parameter int abits = 12
) (
   input  logic             i_clk,
   input  logic             en,
   input  logic             we,
   input  logic [7:0]       strob,
   input  logic [abits-4:0] addr,
   input  logic [63:0]      wdata,
   output logic [63:0]      rdata
);

   logic [63:0] mem [2**(abits-3)];

   always_ff @(posedge i_clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < 8; b++) begin
               if (strob[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/pcie_dma_sram.sv
// rtl/pcie_dma_sram.sv - DMA scratch SRAM terminating the PCIe endpoint memory-request port
// Optional address-range fault check: PCIE_DMA_SRAM_RANGE_CHECK_EN
module pcie_dma_sram
   import pcie_cfg_pkg::*;
#(
   parameter int abits = 12
) (
   input  logic            i_clk,
   input  logic            i_nrst,
   pcie_dma_sram_if.slave  bus
);

   localparam int W  = CFG_PCIE_DMAADDR_WIDTH;
   localparam int BW = CFG_PCIE_DMA_BEATS_WIDTH;
   localparam logic [BW-1:0]  BEAT_ONE = BW'(1);
   localparam logic [W-4:0]   WORD_ONE = (W-3)'(1);

   pcie_dma_sram_state_type state, state_next;

   logic [W-1:0]  cur_addr;
   logic [BW-1:0] beats_left;
   logic          wr_last;
   logic          wr_fault;

   logic          req_hs;
   logic          resp_hs;
   logic          req_oor;
   logic          cur_oor;
   logic [10:0]   nbytes;
   logic [10:0]   beat_sum;

   logic             ram_en;
   logic             ram_we;
   logic [abits-4:0] ram_addr;
   logic [63:0]      ram_rdata;

`ifdef PCIE_DMA_SRAM_RANGE_CHECK_EN
   assign req_oor = |bus.req_mem_addr[W-1:abits];
   assign cur_oor = |cur_addr[W-1:abits];
`else
   assign req_oor = 1'b0;
   assign cur_oor = 1'b0;
`endif

   assign req_hs  = (state == IDLE) && bus.req_mem_valid;
   assign resp_hs = bus.resp_mem_valid && bus.resp_mem_ready;

   // Beat count covers every word touched by [addr, addr+nbytes), so the start offset is added in.
   assign nbytes   = (bus.req_mem_bytes == 10'd0) ? 11'd1024 : {1'b0, bus.req_mem_bytes};
   assign beat_sum = {8'd0, bus.req_mem_addr[2:0]} + nbytes + 11'd7;

   assign ram_we   = (state == IDLE);
   assign ram_en   = (req_hs && bus.req_mem_write && !req_oor) || (state == RD_ISSUE);
   assign ram_addr = (state == IDLE) ? bus.req_mem_addr[abits-1:3] : cur_addr[abits-1:3];

   pcie_dma_sram_bank #(
      .abits (abits)
   ) u_bank (
      .i_clk (i_clk),
      .en    (ram_en),
      .we    (ram_we),
      .strob (bus.req_mem_strob),
      .addr  (ram_addr),
      .wdata (bus.req_mem_data),
      .rdata (ram_rdata)
   );

   always_ff @(posedge i_clk or posedge i_nrst) begin
      if (i_nrst) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge i_clk or posedge i_nrst) begin
      if (i_nrst) begin
         cur_addr   <= '0;
         beats_left <= '0;
         wr_last    <= 1'b0;
         wr_fault   <= 1'b0;
      end else if (req_hs) begin
         cur_addr <= bus.req_mem_addr;
         if (bus.req_mem_write) begin
            wr_last  <= bus.req_mem_last;
            wr_fault <= req_oor;
         end else begin
            beats_left <= beat_sum[10:3];
         end
      end else if ((state == RD_RESP) && resp_hs && (beats_left > BEAT_ONE)) begin
         beats_left <= beats_left - BEAT_ONE;
         cur_addr   <= {cur_addr[W-1:3] + WORD_ONE, 3'b000};
      end
   end

   always_comb begin
      state_next         = state;
      bus.req_mem_ready  = (state == IDLE);
      bus.resp_mem_valid = 1'b0;
      bus.resp_mem_last  = 1'b0;
      bus.resp_mem_fault = 1'b0;
      bus.resp_mem_addr  = '0;
      bus.resp_mem_data  = '0;
      case (state)
         IDLE: begin
            if (bus.req_mem_valid) state_next = bus.req_mem_write ? WR_RESP : RD_ISSUE;
         end
         RD_ISSUE: begin
            state_next = RD_RESP;
         end
         RD_RESP: begin
            bus.resp_mem_valid = 1'b1;
            bus.resp_mem_last  = (beats_left == BEAT_ONE);
            bus.resp_mem_fault = cur_oor;
            bus.resp_mem_addr  = cur_addr;
            bus.resp_mem_data  = cur_oor ? 64'd0 : ram_rdata;
            if (bus.resp_mem_ready) state_next = (beats_left > BEAT_ONE) ? RD_ISSUE : IDLE;
         end
         WR_RESP: begin
            bus.resp_mem_valid = 1'b1;
            bus.resp_mem_last  = wr_last;
            bus.resp_mem_fault = wr_fault;
            bus.resp_mem_addr  = cur_addr;
            if (bus.resp_mem_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pcie_dma_sram.sv
// tb/tb_pcie_dma_sram.sv - randomized self-checking bench for pcie_dma_sram against a byte-array model
module tb_pcie_dma_sram;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [7:0] model_mem [4096];

   pcie_dma_sram_if bus();

   pcie_dma_sram #(.abits(12)) dut (
      .i_clk  (clk),
      .i_nrst (rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit addr_oor(input logic [31:0] a);
`ifdef PCIE_DMA_SRAM_RANGE_CHECK_EN
      return (a[31:12] != 20'd0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [63:0] model_word(input logic [31:0] a);
      logic [63:0] w;
      logic [31:0] base;
      w = '0;
      if (addr_oor(a)) return 64'd0;
      base = a & 32'hFFFF_FFF8;
      for (int k = 0; k < 8; k++) w[8*k +: 8] = model_mem[(base + 32'(k)) & 32'hFFF];
      return w;
   endfunction

   task automatic wait_req_ready(input string who);
      int n;
      n = 0;
      while (!bus.req_mem_ready && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (bus.req_mem_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_req_ready_timeout got %b exp 1", who, bus.req_mem_ready);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s, input logic l);
      logic [31:0] base;
      bit          f;
      f = addr_oor(a);
      wait_req_ready("wr");
      bus.req_mem_valid  = 1'b1;
      bus.req_mem_write  = 1'b1;
      bus.req_mem_addr   = a;
      bus.req_mem_data   = d;
      bus.req_mem_strob  = s;
      bus.req_mem_last   = l;
      bus.resp_mem_ready = 1'b1;
      tick();
      bus.req_mem_valid = 1'b0;
      checks++;
      if (bus.resp_mem_valid !== 1'b1 || bus.resp_mem_last !== l || bus.resp_mem_fault !== f ||
          bus.resp_mem_data !== 64'd0 || bus.resp_mem_addr !== a) begin
         errors++;
         $display("FAIL wr_resp got v=%b l=%b f=%b d=%h a=%h exp v=1 l=%b f=%b d=0 a=%h",
                  bus.resp_mem_valid, bus.resp_mem_last, bus.resp_mem_fault,
                  bus.resp_mem_data, bus.resp_mem_addr, l, f, a);
      end
      if (!f) begin
         base = a & 32'hFFFF_FFF8;
         for (int k = 0; k < 8; k++)
            if (s[k]) model_mem[(base + 32'(k)) & 32'hFFF] = d[8*k +: 8];
      end
      tick();
      checks++;
      if (bus.req_mem_ready !== 1'b1 || bus.resp_mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL wr_next_ready got rdy=%b v=%b exp rdy=1 v=0", bus.req_mem_ready, bus.resp_mem_valid);
      end
   endtask

   task automatic do_read(input logic [31:0] a, input logic [9:0] b, input int stall_beat);
      int          nbytes;
      int          beats;
      logic [31:0] ea;
      logic [63:0] ed;
      logic [63:0] hold_d;
      logic [31:0] hold_a;
      logic        hold_l;
      nbytes = (b == 10'd0) ? 1024 : int'(b);
      beats  = ((int'(a[2:0]) + nbytes - 1) >> 3) + 1;
      wait_req_ready("rd");
      bus.req_mem_valid  = 1'b1;
      bus.req_mem_write  = 1'b0;
      bus.req_mem_addr   = a;
      bus.req_mem_bytes  = b;
      bus.resp_mem_ready = 1'b1;
      tick();
      bus.req_mem_valid = 1'b0;
      checks++;
      if (bus.resp_mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_issue_gap got v=%b exp 0", bus.resp_mem_valid);
      end
      for (int i = 0; i < beats; i++) begin
         tick();
         ea = (i == 0) ? a : (((a >> 3) + 32'(i)) << 3);
         ed = model_word(ea);
         checks++;
         if (bus.resp_mem_valid !== 1'b1 || bus.resp_mem_addr !== ea || bus.resp_mem_data !== ed ||
             bus.resp_mem_last !== (i == beats - 1) || bus.resp_mem_fault !== addr_oor(ea)) begin
            errors++;
            $display("FAIL rd_beat %0d/%0d got v=%b a=%h d=%h l=%b f=%b exp v=1 a=%h d=%h l=%b f=%b",
                     i, beats, bus.resp_mem_valid, bus.resp_mem_addr, bus.resp_mem_data,
                     bus.resp_mem_last, bus.resp_mem_fault, ea, ed, (i == beats - 1), addr_oor(ea));
         end
         if (i == stall_beat) begin
            hold_d = bus.resp_mem_data;
            hold_a = bus.resp_mem_addr;
            hold_l = bus.resp_mem_last;
            bus.resp_mem_ready = 1'b0;
            repeat (5) begin
               tick();
               checks++;
               if (bus.resp_mem_valid !== 1'b1 || bus.resp_mem_data !== hold_d ||
                   bus.resp_mem_addr !== hold_a || bus.resp_mem_last !== hold_l) begin
                  errors++;
                  $display("FAIL rd_stall_stable got v=%b a=%h d=%h exp v=1 a=%h d=%h",
                           bus.resp_mem_valid, bus.resp_mem_addr, bus.resp_mem_data, hold_a, hold_d);
               end
            end
            bus.resp_mem_ready = 1'b1;
         end
         tick();
         if (i != beats - 1) begin
            checks++;
            if (bus.resp_mem_valid !== 1'b0) begin
               errors++;
               $display("FAIL rd_beat_gap %0d got v=%b exp 0", i, bus.resp_mem_valid);
            end
         end
      end
      checks++;
      if (bus.req_mem_ready !== 1'b1 || bus.resp_mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_done_idle got rdy=%b v=%b exp rdy=1 v=0", bus.req_mem_ready, bus.resp_mem_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_mem_valid  = 1'b0;
      bus.req_mem_write  = 1'b0;
      bus.req_mem_bytes  = '0;
      bus.req_mem_addr   = '0;
      bus.req_mem_strob  = '0;
      bus.req_mem_data   = '0;
      bus.req_mem_last   = 1'b0;
      bus.resp_mem_ready = 1'b1;
      repeat (3) tick();
      checks++;
      if (bus.req_mem_ready !== 1'b1 || bus.resp_mem_valid !== 1'b0 || bus.resp_mem_last !== 1'b0 ||
          bus.resp_mem_fault !== 1'b0 || bus.resp_mem_addr !== 32'd0 || bus.resp_mem_data !== 64'd0) begin
         errors++;
         $display("FAIL reset_state got rdy=%b v=%b l=%b f=%b a=%h d=%h exp rdy=1 all else 0",
                  bus.req_mem_ready, bus.resp_mem_valid, bus.resp_mem_last,
                  bus.resp_mem_fault, bus.resp_mem_addr, bus.resp_mem_data);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 512; i++)
         do_write(32'(i) << 3, {$urandom, $urandom}, 8'hFF, 1'b1);
   endtask

   task automatic test_basic();
      do_write(32'h40, 64'h1122334455667788, 8'hFF, 1'b1);
      do_read(32'h40, 10'd8, -1);
      checks++;
      if (model_word(32'h40) !== 64'h1122334455667788) begin
         errors++;
         $display("FAIL basic_model got %h exp 1122334455667788", model_word(32'h40));
      end
      do_write(32'h40, 64'hAAAAAAAABBBBBBBB, 8'h0F, 1'b0);
      checks++;
      if (model_word(32'h40) !== 64'h11223344BBBBBBBB) begin
         errors++;
         $display("FAIL strob_model got %h exp 11223344BBBBBBBB", model_word(32'h40));
      end
      do_read(32'h40, 10'd8, -1);
   endtask

   task automatic test_unaligned();
      do_read(32'h44, 10'd16, -1);
   endtask

   task automatic test_long_burst();
      do_read(32'h0, 10'd0, 2);
   endtask

   task automatic test_range();
      do_read(32'h1000, 10'd8, -1);
      do_write(32'h1000, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1);
      do_read(32'h0, 10'd8, -1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         do_write(32'h100 + 32'(8 * i), {$urandom, $urandom}, 8'(1 << i) | 8'h80, 1'(i & 1));
      do_read(32'h101, 10'd31, -1);
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 40; n++) begin
         a = 32'($urandom_range(0, 4095));
         if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
         if ($urandom_range(0, 1) == 0)
            do_write(a, {$urandom, $urandom}, 8'($urandom), 1'($urandom));
         else
            do_read(a, 10'($urandom_range(0, 300)), int'($urandom_range(0, 3)));
      end
   endtask

   task automatic test_reset_mid_burst();
      wait_req_ready("rst");
      bus.req_mem_valid  = 1'b1;
      bus.req_mem_write  = 1'b0;
      bus.req_mem_addr   = 32'h80;
      bus.req_mem_bytes  = 10'd32;
      bus.resp_mem_ready = 1'b0;
      tick();
      bus.req_mem_valid = 1'b0;
      tick();
      checks++;
      if (bus.resp_mem_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_valid got %b exp 1", bus.resp_mem_valid);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.resp_mem_valid !== 1'b0 || bus.req_mem_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_async_drop got v=%b rdy=%b exp v=0 rdy=1", bus.resp_mem_valid, bus.req_mem_ready);
      end
      tick();
      rst = 1'b0;
      bus.resp_mem_ready = 1'b1;
      tick();
      checks++;
      if (bus.resp_mem_valid !== 1'b0 || bus.req_mem_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_release got v=%b rdy=%b exp v=0 rdy=1", bus.resp_mem_valid, bus.req_mem_ready);
      end
      do_read(32'h80, 10'd32, -1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_fill();
      test_basic();
      test_unaligned();
      test_long_burst();
      test_range();
      test_back_to_back();
      test_random();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
